progmem_bank: RTL



---
 rtl/progmem_bank_pkg.sv | 25 ++
 rtl/progmem_bank_array.sv | 62 ++++++
 rtl/progmem_bank.sv | 124 ++++++++++++
 3 files changed

// File: rtl/progmem_bank_pkg.sv
// Shared types and constants for the progmem_bank program/data memory bank.
package progmem_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    localparam int          STRB_W        = 4;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h0010_0000;
    localparam logic [31:0] DEF_ADDR_MASK = 32'hFFF0_0000;
    localparam logic [31:0] RDATA_OOR     = 32'h0000_0000;
    localparam logic [31:0] RDATA_PERR    = 32'hFFFF_FFFF;

    // Even parity per byte: byte plus its parity bit always has an even number of ones.
    function automatic logic [STRB_W-1:0] byte_parity(input logic [31:0] d);
        logic [STRB_W-1:0] p;
        for (int b = 0; b < STRB_W; b++) begin
            p[b] = ^d[8*b +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/progmem_bank_array.sv
// Byte-enabled single-port synchronous RAM with registered read.
// Define PROGMEM_BANK_PARITY_EN to store and check one even-parity bit per byte.
module progmem_bank_array
   import progmem_bank_pkg::*;
#(
   parameter int    MEM_SIZE_BITS = 10,
   parameter string INIT_FILE     = ""
) (
   input  logic                     clk,
   input  logic                     rd_en,
   input  logic                     wr_en,
   input  logic [STRB_W-1:0]        wstrb,
   input  logic [MEM_SIZE_BITS-1:0] idx,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata,
   output logic                     par_err
);

   localparam int DEPTH = 2 ** MEM_SIZE_BITS;

   logic [31:0] mem [DEPTH];
   logic [31:0] rd_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (rd_en) rd_q <= mem[idx];
   end

   assign rdata = rd_q;

`ifdef PROGMEM_BANK_PARITY_EN
   logic [STRB_W-1:0] par [DEPTH];
   logic [STRB_W-1:0] rd_par_q;
   logic [STRB_W-1:0] wr_par;

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         par[i] = '0;
      end
   end

   assign wr_par = byte_parity(wdata);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) par[idx][b] <= wr_par[b];
         end
      end
      if (rd_en) rd_par_q <= par[idx];
   end

   assign par_err = (byte_parity(rd_q) != rd_par_q);
`else
   assign par_err = 1'b0;
`endif

endmodule

// File: rtl/progmem_bank.sv
// PicoRV32 native-bus memory bank: base/mask decode, wait-state FSM, write lock, sticky error.
// Optional per-byte parity is enabled with PROGMEM_BANK_PARITY_EN (see progmem_bank_array).
//
// state     | meaning
// ST_IDLE   | waiting for a selected request; array access happens on accept
// ST_BUSY   | wait states, counter runs 1..LATENCY-1
// ST_RESP   | ready pulse for one cycle
module progmem_bank
    import progmem_bank_pkg::*;
#(
    parameter int          MEM_SIZE_BITS = 10,
    parameter logic [31:0] BASE_ADDR     = DEF_BASE_ADDR,
    parameter logic [31:0] ADDR_MASK     = DEF_ADDR_MASK,
    parameter int          LATENCY       = 1,
    parameter string       INIT_FILE     = ""
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid,
    output logic              ready,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [31:0]       rdata,
    input  logic              wp_lock,
    output logic              err,
    input  logic              err_clr
);

    localparam logic [31:0] LOW_MASK = (32'd1 << (MEM_SIZE_BITS + 2)) - 32'd1;
    localparam logic [31:0] OOR_MASK = ~ADDR_MASK & ~LOW_MASK;
    localparam logic [3:0]  LAT_LAST = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        sel;
    logic        oor;
    logic        accept;
    logic        is_write;
    logic        wr_en;
    logic        rd_en;
    logic        err_set;
    logic        lat_read;
    logic        rd_zero;
    logic [31:0] arr_rdata;
    logic        par_err;

    assign sel      = valid && ((addr & ADDR_MASK) == BASE_ADDR);
    assign oor      = (addr & OOR_MASK) != 32'h0;
    assign accept   = (state == ST_IDLE) && sel;
    assign is_write = (wstrb != '0);
    assign wr_en    = accept && is_write && !wp_lock && !oor;
    assign rd_en    = accept && !is_write && !oor;

    assign err_set = (accept && oor)
                   || (accept && is_write && wp_lock)
                   || ((state == ST_RESP) && lat_read && !rd_zero && par_err);

    progmem_bank_array #(
        .MEM_SIZE_BITS (MEM_SIZE_BITS),
        .INIT_FILE     (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .wstrb   (wstrb),
        .idx     (addr[MEM_SIZE_BITS+1:2]),
        .wdata   (wdata),
        .rdata   (arr_rdata),
        .par_err (par_err)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sel) state_nxt = (LATENCY == 1) ? ST_RESP : ST_BUSY;
            ST_BUSY: if (cnt == LAT_LAST) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == ST_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 4'd0;
        end else if (accept) begin
            cnt <= 4'd1;
        end else if (state == ST_BUSY && cnt != LAT_LAST) begin
            cnt <= cnt + 4'd1;
        end else begin
            cnt <= 4'd0;
        end
    end

    // rd_zero selects the out-of-range response; it also covers the post-reset value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_read <= 1'b0;
            rd_zero  <= 1'b1;
        end else if (accept) begin
            lat_read <= !is_write;
            if (!is_write) rd_zero <= oor;
        end
    end

    assign rdata = rd_zero ? RDATA_OOR : (par_err ? RDATA_PERR : arr_rdata);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)        err <= 1'b0;
        else if (err_set) err <= 1'b1;
        else if (err_clr) err <= 1'b0;
    end

endmodule
